usb_rx_pkt_ctrl: RTL and testbench

Packet-level controller that sequences the USB 1.1 receiver's RX FIFO.
- Watches rcving, r_error and PID.
- Drains payload bytes through a single-entry valid/ready output register.
- Enforces a maximum payload length and an inter-byte timeout.
- Emits one status pulse per packet carrying length, PID and error code.
- Sits between the usb11 receiver and the downstream endpoint/buffer logic.

---
 rtl/usb_rx_pkt_ctrl_if.sv | 32 +++
 rtl/usb_rx_pkt_ctrl.sv | 174 +++++++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Handshake and status bundle between the USB 1.1 receiver/RX FIFO, the packet
// controller and the downstream endpoint logic.
interface usb_rx_pkt_ctrl_if #(
  parameter int LEN_W = 7
);
  logic             rcving;
  logic             r_error;
  logic [3:0]       PID;
  logic             empty;
  logic             full;
  logic [7:0]       r_data;
  logic             r_enable;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             pkt_done;
  logic [LEN_W-1:0] pkt_len;
  logic [3:0]       pkt_pid;
  logic [1:0]       pkt_err;

  // The controller side.
  modport master (
    input  rcving, r_error, PID, empty, full, r_data, out_ready,
    output r_enable, out_data, out_valid, pkt_done, pkt_len, pkt_pid, pkt_err
  );

  // The environment side: receiver, FIFO and downstream consumer.
  modport slave (
    output rcving, r_error, PID, empty, full, r_data, out_ready,
    input  r_enable, out_data, out_valid, pkt_done, pkt_len, pkt_pid, pkt_err
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level sequencer for the USB 1.1 RX FIFO: drains payload bytes through a
// one-entry valid/ready register, enforces length and inter-byte timeout, reports status.
module usb_rx_pkt_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_rx_pkt_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV      = 3'd1,
    FLUSH     = 3'd2,
    DRAIN_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_RX  = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [3:0]       pkt_pid_q, pkt_pid_d;
  logic [1:0]       pkt_err_q, pkt_err_d;
  logic             r_error_q;

  logic discarding;
  logic pop;
  logic accept;
  logic err_rise;
  logic timeout_hit;
  logic start_pkt;
  logic finish_pkt;
  logic r_enable_c;
  logic pkt_done_c;
  logic unused_full;

  // FIFO full is pure backpressure here; the receiver reports its own overflow on r_error.
  assign unused_full = bus.full;

  assign discarding  = (cnt_q == LEN_W'(MAX_LEN));
  assign pop         = ((state_q == RECV) || (state_q == FLUSH)) && !bus.empty &&
                       (!out_valid_q || bus.out_ready || discarding);
  assign accept      = out_valid_q && bus.out_ready;
  assign err_rise    = bus.r_error && !r_error_q;
  assign timeout_hit = (state_q == RECV) && bus.empty && (to_q == TO_W'(TIMEOUT - 1));
  assign start_pkt   = (state_q == IDLE) && bus.rcving;
  assign finish_pkt  = (state_q == DRAIN_OUT) && !out_valid_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.rcving) state_d = RECV;
      RECV:      if (timeout_hit || !bus.rcving) state_d = FLUSH;
      FLUSH:     if (bus.empty) state_d = DRAIN_OUT;
      DRAIN_OUT: if (!out_valid_q) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    to_d        = to_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_len_d   = pkt_len_q;
    pkt_pid_d   = pkt_pid_q;
    pkt_err_d   = pkt_err_q;

    if (start_pkt) begin
      cnt_d = '0;
      to_d  = '0;
      err_d = ERR_OK;
    end

    // Earlier errors take precedence over later ones, so each source only fills an empty code.
    if ((state_q == RECV) && bus.r_error && (err_d == ERR_OK)) begin
      err_d = ERR_RX;
    end
    if (((state_q == FLUSH) || (state_q == DRAIN_OUT)) && err_rise && (err_d == ERR_OK)) begin
      err_d = ERR_RX;
    end

    if (accept) begin
      out_valid_d = 1'b0;
    end
    if (pop) begin
      if (!discarding) begin
        out_data_d  = bus.r_data;
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + LEN_W'(1);
      end else if (err_d == ERR_OK) begin
        err_d = ERR_LEN;
      end
    end

    if (state_q == RECV) begin
      if (pop) begin
        to_d = '0;
      end else if (bus.empty) begin
        to_d = to_q + TO_W'(1);
      end
    end
    if (timeout_hit && (err_d == ERR_OK)) begin
      err_d = ERR_TO;
    end

    // Status is loaded on entry to DONE so it is already valid while pkt_done is high.
    if (finish_pkt) begin
      pkt_len_d = cnt_q;
      pkt_pid_d = bus.PID;
      pkt_err_d = err_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= '0;
      to_q        <= '0;
      err_q       <= ERR_OK;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_len_q   <= '0;
      pkt_pid_q   <= '0;
      pkt_err_q   <= ERR_OK;
      r_error_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_len_q   <= pkt_len_d;
      pkt_pid_q   <= pkt_pid_d;
      pkt_err_q   <= pkt_err_d;
      r_error_q   <= bus.r_error;
    end
  end

  always_comb begin
    r_enable_c = pop;
    pkt_done_c = (state_q == DONE);
  end

  assign bus.r_enable  = r_enable_c;
  assign bus.pkt_done  = pkt_done_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.pkt_pid   = pkt_pid_q;
  assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl: a queue models the RX FIFO; a second DUT
// with MAX_LEN=2 covers the length-overflow path.
module tb_usb_rx_pkt_ctrl;
  localparam int LEN_W = 7;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rcving = 1'b0;
  logic       r_error = 1'b0;
  logic       out_ready = 1'b0;
  logic       empty = 1'b1;
  logic       full = 1'b0;
  logic [3:0] pid = 4'h0;
  logic [7:0] r_data = 8'h00;
  logic       sel = 1'b0;

  logic [7:0] fifo_q[$];
  logic [7:0] rx_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  int cap_fifo = 0;
  logic [LEN_W-1:0] cap_len = '0;
  logic [3:0]       cap_pid = '0;
  logic [1:0]       cap_err = '0;

  always #5 clk = ~clk;

  usb_rx_pkt_ctrl_if #(.LEN_W(LEN_W)) bus ();
  usb_rx_pkt_ctrl_if #(.LEN_W(LEN_W)) bus2 ();

  assign bus.rcving     = rcving;
  assign bus.r_error    = r_error;
  assign bus.PID        = pid;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.r_data     = r_data;
  assign bus.out_ready  = out_ready;
  assign bus2.rcving    = rcving;
  assign bus2.r_error   = r_error;
  assign bus2.PID       = pid;
  assign bus2.empty     = empty;
  assign bus2.full      = full;
  assign bus2.r_data    = r_data;
  assign bus2.out_ready = out_ready;

  usb_rx_pkt_ctrl #(.MAX_LEN(64), .LEN_W(LEN_W), .TIMEOUT(200), .TO_W(8)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  usb_rx_pkt_ctrl #(.MAX_LEN(2), .LEN_W(LEN_W), .TIMEOUT(200), .TO_W(8)) u_dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus2)
  );

  wire             s_ren  = sel ? bus2.r_enable  : bus.r_enable;
  wire             s_ov   = sel ? bus2.out_valid : bus.out_valid;
  wire [7:0]       s_od   = sel ? bus2.out_data  : bus.out_data;
  wire             s_done = sel ? bus2.pkt_done  : bus.pkt_done;
  wire [LEN_W-1:0] s_len  = sel ? bus2.pkt_len   : bus.pkt_len;
  wire [3:0]       s_pid  = sel ? bus2.pkt_pid   : bus.pkt_pid;
  wire [1:0]       s_err  = sel ? bus2.pkt_err   : bus.pkt_err;

  task automatic refresh();
    empty  = (fifo_q.size() == 0);
    full   = (fifo_q.size() >= 8);
    r_data = empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt - start, 1);
  endtask

  // FIFO pops and downstream accepts are sampled with pre-edge values.
  initial begin : mon
    logic do_pop;
    forever begin
      @(posedge clk);
      cyc++;
      do_pop = s_ren;
      if (n_rst && s_ov && out_ready) begin
        rx_q.push_back(s_od);
        last_acc_cyc = cyc;
      end
      if (s_done) begin
        done_cnt++;
        done_cyc = cyc;
        cap_len  = s_len;
        cap_pid  = s_pid;
        cap_err  = s_err;
        cap_fifo = fifo_q.size();
      end
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] exp3 [4];
    int start;
    int cyc0;
    exp3 = '{8'h00, 8'h3F, 8'hFF, 8'hA5};

    // 1: reset and idle lines
    tick(3);
    n_rst = 1'b1;
    tick(100);
    check("t1_no_done", done_cnt, 0);
    check("t1_out_valid", bus.out_valid, 0);
    check("t1_r_enable", bus.r_enable, 0);
    check("t1_out_data", bus.out_data, 0);
    check("t1_pkt_len", bus.pkt_len, 0);
    check("t1_pkt_pid", bus.pkt_pid, 0);
    check("t1_pkt_err", bus.pkt_err, 0);

    // 2: single byte packet
    out_ready = 1'b1;
    pid = 4'b0001;
    rcving = 1'b1;
    tick(3);
    push(8'hC9);
    tick(5);
    rcving = 1'b0;
    wait_done("t2_done", 100);
    check("t2_beats", rx_q.size(), 1);
    check("t2_byte0", rx_q[0], 8'hC9);
    check("t2_len", cap_len, 1);
    check("t2_pid", cap_pid, 4'b0001);
    check("t2_err", cap_err, 0);
    tick(10);

    // 3: four bytes under backpressure
    rx_q.delete();
    out_ready = 1'b0;
    pid = 4'b0011;
    rcving = 1'b1;
    tick(2);
    check("t3_len_held", s_len, 1);
    for (int i = 0; i < 4; i++) begin
      push(exp3[i]);
      tick(6);
    end
    check("t3_valid_stalled", s_ov, 1);
    check("t3_fifo_backlog", fifo_q.size(), 3);
    rcving = 1'b0;
    start = done_cnt;
    tick(5);
    check("t3_no_early_done", done_cnt - start, 0);
    out_ready = 1'b1;
    wait_done("t3_done", 100);
    check("t3_beats", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_byte%0d", i), rx_q[i], exp3[i]);
    check("t3_len", cap_len, 4);
    check("t3_pid", cap_pid, 4'b0011);
    check("t3_err", cap_err, 0);
    check("t3_done_after_accept", done_cyc > last_acc_cyc, 1);
    tick(10);

    // 4: MAX_LEN=2 instance, three bytes
    sel = 1'b1;
    rx_q.delete();
    pid = 4'b1011;
    rcving = 1'b1;
    tick(2);
    push(8'h11);
    tick(4);
    push(8'h22);
    tick(4);
    push(8'h33);
    tick(4);
    rcving = 1'b0;
    wait_done("t4_done", 100);
    check("t4_beats", rx_q.size(), 2);
    check("t4_byte0", rx_q[0], 8'h11);
    check("t4_byte1", rx_q[1], 8'h22);
    check("t4_len", cap_len, 2);
    check("t4_err", cap_err, 2'b10);
    check("t4_pid", cap_pid, 4'b1011);
    check("t4_fifo_empty", cap_fifo, 0);
    tick(10);
    sel = 1'b0;

    // 5: rx error then timeout, first error wins
    rx_q.delete();
    pid = 4'b0011;
    rcving = 1'b1;
    tick(2);
    push(8'hAA);
    tick(4);
    r_error = 1'b1;
    wait_done("t5_done", 400);
    rcving = 1'b0;
    r_error = 1'b0;
    check("t5_err", cap_err, 2'b01);
    check("t5_len", cap_len, 1);
    check("t5_byte0", rx_q[0], 8'hAA);
    tick(10);

    // 6: stuck rcving with no bytes, then reset mid-packet
    pid = 4'b0000;
    cyc0 = cyc;
    rcving = 1'b1;
    wait_done("t6_done", 300);
    check("t6_latency", done_cyc - cyc0, 204);
    check("t6_err", cap_err, 2'b11);
    check("t6_len", cap_len, 0);
    tick(3);
    out_ready = 1'b0;
    push(8'h5A);
    tick(3);
    check("t6_valid_before_rst", bus.out_valid, 1);
    check("t6_status_before_rst", bus.pkt_err, 2'b11);
    n_rst = 1'b0;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_r_enable", bus.r_enable, 0);
    check("t6_rst_pkt_done", bus.pkt_done, 0);
    check("t6_rst_pkt_err", bus.pkt_err, 0);
    check("t6_rst_pkt_len", bus.pkt_len, 0);
    start = done_cnt;
    rcving = 1'b0;
    fifo_q.delete();
    refresh();
    tick(3);
    n_rst = 1'b1;
    tick(20);
    check("t6_no_done_after_rst", done_cnt - start, 0);
    check("t6_idle_valid", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
